irq_capture: RTL and testbench
==============================

# irq_capture

Request-capture and handshake stage that feeds the 8-to-3 priority encoder and consumes its code. Eight asynchronous request lines are synchronised, rising edges are latched into a pending register, and the masked pending vector drives the encoder's `a` input. The encoder's 3-bit code returns to this block, which offers it to the downstream consumer with a valid/ack handshake and clears the serviced pending bit.

## Interface
Parameters:
- `N_REQ`, 8: request count. Fixed at 8 to match the encoder.
- `IDX_W`, 3: code width. Fixed at 3.
- `SYNC_STAGES`, 2: synchroniser depth per request line, ≥2.

Ports:
- `clk` input 1: single clock. All state is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_in` input 8: asynchronous request levels. A rising edge posts a request.
- `mask` input 8: 1 enables the bit. Synchronous to `clk`.
- `en` input 1: global enable, shared with the encoder's `en`.
- `pend_out` output 8: `pending & mask`, drives the encoder's `a`.
- `code_in` input 3: the encoder's `out`.
- `irq_valid` output 1: an index is offered.
- `irq_idx` output 3: the offered index. Stable while `irq_valid` is high.
- `irq_ack` input 1: the consumer accepts the offered index.
- `ovf` output 8: sticky per-bit overflow flags.
- `ovf_clr` input 8: per-bit overflow clear.

## Operation
- Synchroniser: each `req_in` bit passes through `SYNC_STAGES` flops, then a delay flop. An edge is detected when `sync=1` and `prev=0`.
- Edge detected on bit i: `pending[i] <= 1`. Pending bits are captured regardless of `mask` and `en`.
- `pend_out` is combinational: `pending & mask`.
- FSM states:
  - IDLE → OFFER when `en=1` and `|pend_out`. `irq_idx <= code_in` is latched at this edge.
  - OFFER: `irq_valid=1`. Holds until `irq_ack`. Changes to `en`, `mask` or `code_in` are ignored while in OFFER.
  - OFFER with `irq_ack=1` → GAP. `pending[irq_idx] <= 0` at this edge.
  - GAP → IDLE unconditionally. The one-cycle gap lets the encoder settle on the new vector.
- Set and clear of the same bit in the same cycle: set wins. The bit stays pending and no overflow is flagged.
- Overflow: an edge on bit i while `pending[i]=1` and the bit is not being cleared that cycle gives `ovf[i] <= 1`.
  - If set and `ovf_clr[i]` are simultaneous, set wins.
- `irq_ack` outside OFFER is ignored.
- The encoder outputs `3'b000` for both "bit 0" and "nothing pending". This block therefore qualifies on `|pend_out`, never on the code value.
- Reset values: all synchroniser flops 0, `pending=0`, `ovf=0`, FSM=IDLE, `irq_valid=0`, `irq_idx=0`, `pend_out=0`.
- Reset asserted mid-handshake discards the offer. No pending bit survives.

## Timing
- With `SYNC_STAGES=2`, `req_in` is first sampled high at edge E0. The edge is detected at E2 and `pend_out` goes high after E2.
- `irq_valid` goes high after E3, if IDLE, `en=1` and the bit is unmasked.
- The ack edge is Ea. After Ea, `irq_valid=0` and the pending bit is cleared. GAP occupies Ea+1. The earliest next `irq_valid` is after Ea+2.
- Peak throughput: one accepted request per 3 cycles.
- A `req_in` held high posts one request only. It must fall and rise again to repost.

## Configuration
- Macro `IRQ_CAPTURE_OVF_EN`.
- Defined: the overflow logic and `ovf` register are built as described.
- Undefined: `ovf` is tied to `8'h00`, `ovf_clr` is ignored and no overflow flops are inferred.
- All other behaviour is identical in both builds.

## Structure
- Package `irq_pkg` holds:
  - `N_REQ` and `IDX_W` constants.
  - The FSM state enum `irq_state_t` (`IDLE`, `OFFER`, `GAP`).
  - Reset-value constants.
- Sub-module `req_sync`: a single-bit synchroniser plus rising-edge detector, parameterised by `SYNC_STAGES`, instantiated 8 times.
- The FSM, pending, overflow and handshake logic stay in `irq_capture`.
- The testbench instantiates `irq_capture` together with the existing encoder, connected as in the design.

## Test plan
- Reset then idle: `rst=1` for 2 cycles with `req_in=8'hFF` → all outputs 0 during reset. After release, pending posts only once `req_in` shows a fresh rising edge.
- Single request: `mask=8'hFF`, `en=1`, pulse `req_in[5]` → `pend_out=8'h20` after E2, `irq_valid=1`/`irq_idx=5` after E3. Ack → `pend_out=8'h00`, `irq_valid=0` during GAP.
- Priority and order: edges on bits 2 and 6 in the same cycle → first offer `idx=6`. After ack and GAP, offer `idx=2`. After the second ack, `pend_out=0`.
- Mask/en gating: `mask=8'hFB`, edge on bit 2 → `pend_out=0` and no offer. Then set `mask=8'hFF` with `en=0` → no offer. Set `en=1` → `idx=2` offered.
- Simultaneous set/clear and overflow (`IRQ_CAPTURE_OVF_EN` defined):
  - New edge on bit 3 during its ack cycle → `pending[3]` stays 1, `ovf[3]=0`.
  - Another edge while pending → `ovf[3]=1`.
  - Pulse `ovf_clr[3]` → `ovf[3]=0`.
  - Undefined build: `ovf` stays `8'h00` throughout.
- Reset mid-offer: assert `rst` while `irq_valid=1` with `idx=7` → next cycle `irq_valid=0` and `pending=0`. An `irq_ack` held high in that cycle has no effect.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and reset values for irq_capture.
package irq_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2
    } irq_state_t;

    localparam logic [N_REQ-1:0] PEND_RST  = '0;
    localparam logic [N_REQ-1:0] OVF_RST   = '0;
    localparam logic [IDX_W-1:0] IDX_RST   = '0;
    localparam irq_state_t       STATE_RST = IDLE;

    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/req_sync.sv
// Single-bit synchroniser followed by a rising-edge detector.
module req_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_capture.sv
// Request capture and valid/ack handshake around the 8-to-3 priority encoder.
// Optional overflow flags are built when IRQ_CAPTURE_OVF_EN is defined.
module irq_capture
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] mask,
    input  logic             en,
    output logic [N_REQ-1:0] pend_out,
    input  logic [IDX_W-1:0] code_in,
    output logic             irq_valid,
    output logic [IDX_W-1:0] irq_idx,
    input  logic             irq_ack,
    output logic [N_REQ-1:0] ovf,
    input  logic [N_REQ-1:0] ovf_clr
);

    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] pend_q;
    logic [N_REQ-1:0] clr;
    irq_state_t       state_q;
    irq_state_t       state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    for (genvar i = 0; i < N_REQ; i++) begin : g_sync
        req_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (req_in[i]),
            .rise(rise[i])
        );
    end

    assign pend_out  = pend_q & mask;
    assign irq_valid = (state_q == OFFER);
    assign irq_idx   = idx_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr     = '0;
        unique case (state_q)
            IDLE: begin
                // Code 0 is ambiguous, so qualify on the vector itself.
                if (en && (|pend_out)) begin
                    state_d = OFFER;
                    idx_d   = code_in;
                end
            end
            OFFER: begin
                if (irq_ack) begin
                    state_d = GAP;
                    clr     = idx_onehot(idx_q);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_RST;
            idx_q   <= IDX_RST;
            pend_q  <= PEND_RST;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= (pend_q & ~clr) | rise;
        end
    end

`ifdef IRQ_CAPTURE_OVF_EN
    logic [N_REQ-1:0] ovf_q;

    // A repost that coincides with its own clear is not lost, so no flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= OVF_RST;
        end else begin
            ovf_q <= (ovf_q & ~ovf_clr) | (rise & pend_q & ~clr);
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ^ovf_clr;
    assign ovf            = OVF_RST;
`endif

endmodule

// File: tb/tb_irq_capture.sv
// Directed bench for irq_capture, with a behavioural 8-to-3 priority encoder.
module tb_irq_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_in;
    logic [7:0] mask;
    logic       en;
    logic [7:0] pend_out;
    logic [2:0] code_in;
    logic       irq_valid;
    logic [2:0] irq_idx;
    logic       irq_ack;
    logic [7:0] ovf;
    logic [7:0] ovf_clr;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    irq_capture #(
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .mask     (mask),
        .en       (en),
        .pend_out (pend_out),
        .code_in  (code_in),
        .irq_valid(irq_valid),
        .irq_idx  (irq_idx),
        .irq_ack  (irq_ack),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    // Encoder: highest set bit wins, 0 when idle or disabled.
    always_comb begin
        code_in = 3'd0;
        if (en) begin
            for (int i = 0; i < 8; i++) begin
                if (pend_out[i]) code_in = 3'(i);
            end
        end
    end

`ifdef IRQ_CAPTURE_OVF_EN
    localparam logic [7:0] OVF3 = 8'h08;
`else
    localparam logic [7:0] OVF3 = 8'h00;
`endif

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_offer(input string tag, input logic v,
                             input logic [2:0] idx);
        chk({tag, "_valid"}, {7'd0, irq_valid}, {7'd0, v});
        if (v) chk({tag, "_idx"}, {5'd0, irq_idx}, {5'd0, idx});
    endtask

    initial begin
        rst     = 1'b1;
        req_in  = 8'hFF;
        mask    = 8'hFF;
        en      = 1'b1;
        irq_ack = 1'b0;
        ovf_clr = 8'h00;

        // Reset with all requests high
        step(1);
        chk("rst_pend", pend_out, 8'h00);
        chk_offer("rst", 1'b0, 3'd0);
        step(1);
        chk("rst_pend2", pend_out, 8'h00);
        chk("rst_idx", {5'd0, irq_idx}, 8'h00);
        chk("rst_ovf", ovf, 8'h00);
        req_in = 8'h00;
        rst    = 1'b0;
        step(4);
        chk("idle_pend", pend_out, 8'h00);
        chk_offer("idle", 1'b0, 3'd0);

        // Single request on bit 5
        req_in[5] = 1'b1;
        step(2);
        chk("s5_e1_pend", pend_out, 8'h00);
        step(1);
        chk("s5_e2_pend", pend_out, 8'h20);
        chk_offer("s5_e2", 1'b0, 3'd0);
        step(1);
        chk_offer("s5_e3", 1'b1, 3'd5);
        step(1);
        chk_offer("s5_hold", 1'b1, 3'd5);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        chk("s5_gap_pend", pend_out, 8'h00);
        chk_offer("s5_gap", 1'b0, 3'd0);
        step(3);
        chk_offer("s5_held_no_repost", 1'b0, 3'd0);
        chk("s5_held_pend", pend_out, 8'h00);
        req_in = 8'h00;
        step(4);

        // Bits 2 and 6 together
        req_in = 8'h44;
        step(3);
        chk("p_pend", pend_out, 8'h44);
        step(1);
        chk_offer("p_first", 1'b1, 3'd6);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        chk("p_gap_pend", pend_out, 8'h04);
        chk_offer("p_gap", 1'b0, 3'd0);
        step(1);
        chk_offer("p_idle", 1'b0, 3'd0);
        step(1);
        chk_offer("p_second", 1'b1, 3'd2);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        chk("p_done_pend", pend_out, 8'h00);
        req_in = 8'h00;
        step(4);

        // Mask and enable gating
        mask      = 8'hFB;
        req_in[2] = 1'b1;
        step(3);
        chk("m_pend", pend_out, 8'h00);
        step(2);
        chk_offer("m_masked", 1'b0, 3'd0);
        mask = 8'hFF;
        en   = 1'b0;
        step(1);
        chk("m_unmasked_pend", pend_out, 8'h04);
        step(2);
        chk_offer("m_en0", 1'b0, 3'd0);
        en = 1'b1;
        step(1);
        chk_offer("m_en1", 1'b1, 3'd2);
        mask = 8'h00;
        en   = 1'b0;
        step(2);
        chk_offer("m_offer_ignores", 1'b1, 3'd2);
        mask    = 8'hFF;
        en      = 1'b1;
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        chk("m_done_pend", pend_out, 8'h00);
        req_in = 8'h00;
        step(4);

        // Repost during own ack, then overflow
        req_in[3] = 1'b1;
        step(4);
        chk_offer("o_offer", 1'b1, 3'd3);
        req_in[3] = 1'b0;
        step(3);
        req_in[3] = 1'b1;
        step(2);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        chk_offer("o_ack_gap", 1'b0, 3'd0);
        chk("o_setwins_pend", pend_out, 8'h08);
        chk("o_setwins_ovf", ovf, 8'h00);
        req_in[3] = 1'b0;
        step(3);
        chk_offer("o_reoffer", 1'b1, 3'd3);
        req_in[3] = 1'b1;
        step(2);
        chk("o_pre_ovf", ovf, 8'h00);
        step(1);
        chk("o_ovf_set", ovf, OVF3);
        ovf_clr[3] = 1'b1;
        step(1);
        ovf_clr = 8'h00;
        chk("o_ovf_clr", ovf, 8'h00);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        chk("o_done_pend", pend_out, 8'h00);
        req_in = 8'h00;
        step(4);

        // Reset while offering bit 7, ack held high
        req_in[7] = 1'b1;
        step(4);
        chk_offer("r_offer", 1'b1, 3'd7);
        rst     = 1'b1;
        irq_ack = 1'b1;
        req_in  = 8'h00;
        step(1);
        chk_offer("r_valid", 1'b0, 3'd0);
        chk("r_pend", pend_out, 8'h00);
        chk("r_idx", {5'd0, irq_idx}, 8'h00);
        rst = 1'b0;
        step(1);
        chk_offer("r_after", 1'b0, 3'd0);
        irq_ack = 1'b0;
        step(4);
        chk("r_pend_after", pend_out, 8'h00);
        chk("r_ovf_after", ovf, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
